// File: rtl/if_id_pkg.sv
// Shared types and constants for the fetch stage and IF/ID register.
package if_id_pkg;

  // Fetch FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  // Instruction word presented to decode on a bubble.
  localparam logic [31:0] INST_NOP = 32'h0000_0000;

  // Sequential fetch increment in bytes.
  localparam int PC_STEP = 4;

  // Default first fetch address after reset.
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry {valid, addr, inst} holding buffer for a fetch response that
// cannot go straight into IF/ID. Priority: flush > write > read/clear, so a
// write that lands in the same cycle as a read leaves the new entry valid.
module if_skid_buf
  import if_id_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_inst,
  input  logic              rd_en,
  output logic              valid,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       inst
);

  // Entry update: flush drops it, write fills it, read empties it.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      addr  <= '0;
      inst  <= INST_NOP;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (wr_en) begin
      valid <= 1'b1;
      addr  <= wr_addr;
      inst  <= wr_inst;
    end else if (rd_en) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// Fetch stage plus IF/ID pipeline register.
// Optional build macro IF_ID_PERF_EN adds perf_fetch_cnt / perf_drop_cnt.
//
// Handshake: a fetch is accepted on any posedge where imem_req && imem_ready;
// imem_req stays high with a stable imem_addr until accepted. Exactly one
// request may be outstanding; its response is the first imem_rvalid seen in
// WAIT (never in the acceptance cycle), and imem_rvalid outside WAIT is
// ignored. There is no backpressure on the response side: stalled responses
// are parked in the skid buffer.
module if_id_stage
  import if_id_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic [ADDR_W-1:0] IF_ID_PC,
  output logic [31:0]       IF_ID_inst,
  output logic              IF_ID_Enable,
`ifdef IF_ID_PERF_EN
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_drop_cnt,
`endif
  output fetch_state_t      dbg_state
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] req_pc;
  logic              discard;

  logic              skid_valid;
  logic [ADDR_W-1:0] skid_addr;
  logic [31:0]       skid_inst;

  logic [ADDR_W-1:0] redirect_target;
  logic              resp_seen;
  logic              resp_fire;
  logic              resp_drop;
  logic              skid_wr;
  logic              skid_rd;
  logic              skid_empty_next;

  assign redirect_target = {redirect_pc[ADDR_W-1:2], 2'b00};

  // A response only counts in WAIT; it is used unless it is stale.
  assign resp_seen = (state == WAIT) && imem_rvalid;
  assign resp_fire = resp_seen && !discard;
  assign resp_drop = resp_seen && (discard || redirect_valid);

  // Park the response when decode is stalled or older data is still parked.
  assign skid_wr = resp_fire && !redirect_valid && (stall || skid_valid);
  assign skid_rd = skid_valid && !stall && !redirect_valid;
  assign skid_empty_next = !skid_wr && (!skid_valid || skid_rd);

  assign imem_req  = (state == REQ);
  assign imem_addr = fetch_pc;
  assign dbg_state = state;

  if_skid_buf #(.ADDR_W(ADDR_W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .flush   (redirect_valid),
    .wr_en   (skid_wr),
    .wr_addr (req_pc),
    .wr_inst (imem_rdata),
    .rd_en   (skid_rd),
    .valid   (skid_valid),
    .addr    (skid_addr),
    .inst    (skid_inst)
  );

  // Fetch FSM and PC: redirect overrides everything, else sequential fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      discard  <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_target;
      case (state)
        REQ: begin
          if (imem_ready) begin
            // The old request is already in flight; its response is stale.
            state   <= WAIT;
            req_pc  <= fetch_pc;
            discard <= 1'b1;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            state   <= REQ;
            discard <= 1'b0;
          end else begin
            discard <= 1'b1;
          end
        end
        default: state <= REQ;
      endcase
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (imem_ready) begin
            state    <= WAIT;
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (discard) begin
              discard <= 1'b0;
              state   <= REQ;
            end else begin
              state <= skid_empty_next ? REQ : HOLD;
            end
          end
        end
        HOLD: begin
          if (skid_empty_next) state <= REQ;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // IF/ID register: bubble on redirect, hold on stall, skid before fresh data.
  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      IF_ID_PC     <= '0;
      IF_ID_inst   <= INST_NOP;
      IF_ID_Enable <= 1'b0;
    end else if (!stall) begin
      if (skid_valid) begin
        IF_ID_PC     <= skid_addr;
        IF_ID_inst   <= skid_inst;
        IF_ID_Enable <= 1'b1;
      end else if (resp_fire) begin
        IF_ID_PC     <= req_pc;
        IF_ID_inst   <= imem_rdata;
        IF_ID_Enable <= 1'b1;
      end else begin
        IF_ID_PC     <= '0;
        IF_ID_inst   <= INST_NOP;
        IF_ID_Enable <= 1'b0;
      end
    end
  end

`ifdef IF_ID_PERF_EN
  logic fetch_inc;
  logic flush_drop;

  assign fetch_inc  = !redirect_valid && !stall && (skid_valid || resp_fire);
  assign flush_drop = redirect_valid && skid_valid;

  // Event counters: instructions delivered and responses thrown away.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_drop_cnt  <= '0;
    end else begin
      perf_fetch_cnt <= perf_fetch_cnt + 32'(fetch_inc);
      perf_drop_cnt  <= perf_drop_cnt + 32'(resp_drop) + 32'(flush_drop);
    end
  end
`else
  logic unused_drop;
  assign unused_drop = resp_drop;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Directed testbench for if_id_stage. Instruction memory is a small model
// that answers one cycle after acceptance with rdata = addr | 0x1000;
// mem_mute delays the answer.
module tb_if_id_stage;
  import if_id_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] IF_ID_PC;
  logic [31:0] IF_ID_inst;
  logic        IF_ID_Enable;
  fetch_state_t dbg_state;
`ifdef IF_ID_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_drop_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Clock and reset
  always #5 clk = ~clk;

  if_id_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .IF_ID_PC       (IF_ID_PC),
    .IF_ID_inst     (IF_ID_inst),
    .IF_ID_Enable   (IF_ID_Enable),
`ifdef IF_ID_PERF_EN
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_drop_cnt  (perf_drop_cnt),
`endif
    .dbg_state      (dbg_state)
  );

  // Instruction memory model
  logic        mem_pend = 1'b0;
  logic        mem_mute;
  logic [31:0] mem_addr = 32'h0;

  assign imem_rvalid = mem_pend && !mem_mute;
  assign imem_rdata  = mem_addr | 32'h0000_1000;

  always @(posedge clk) begin
    if (imem_rvalid) mem_pend <= 1'b0;
    if (imem_req && imem_ready) begin
      mem_pend <= 1'b1;
      mem_addr <= imem_addr;
    end
  end

  // Driver: advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_ready = 1'b1; mem_mute = 1'b0;
    tick(); tick();
    n_tests++;
    if ({IF_ID_PC, IF_ID_inst, IF_ID_Enable} !== {32'h0, 32'h0, 1'b0}) begin
      n_fail++; $display("FAIL reset_ifid: got %h/%h/%b want 0/0/0", IF_ID_PC, IF_ID_inst, IF_ID_Enable);
    end
    n_tests++;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
    n_tests++;
    if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want IDLE", dbg_state); end
`ifdef IF_ID_PERF_EN
    n_tests++;
    if ({perf_fetch_cnt, perf_drop_cnt} !== 64'h0) begin
      n_fail++; $display("FAIL reset_perf: got %0d/%0d want 0/0", perf_fetch_cnt, perf_drop_cnt);
    end
`endif
    rst = 1'b0;
    tick();
    n_tests++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      n_fail++; $display("FAIL first_req: got %b/%h want 1/00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_fetch();
    tick();
    n_tests++;
    if ({imem_req, IF_ID_Enable} !== 2'b00) begin
      n_fail++; $display("FAIL fetch_wait0: got req=%b en=%b want 0/0", imem_req, IF_ID_Enable);
    end
    tick();
    n_tests++;
    if ({IF_ID_PC, IF_ID_inst, IF_ID_Enable} !== {32'h0, 32'h1000, 1'b1}) begin
      n_fail++; $display("FAIL fetch_i0: got %h/%h/%b want 0/1000/1", IF_ID_PC, IF_ID_inst, IF_ID_Enable);
    end
    n_tests++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h4}) begin
      n_fail++; $display("FAIL fetch_req4: got %b/%h want 1/4", imem_req, imem_addr);
    end
    tick();
    n_tests++;
    if ({IF_ID_PC, IF_ID_inst, IF_ID_Enable} !== {32'h0, 32'h0, 1'b0}) begin
      n_fail++; $display("FAIL fetch_bubble: got %h/%h/%b want 0/0/0", IF_ID_PC, IF_ID_inst, IF_ID_Enable);
    end
    tick();
    n_tests++;
    if ({IF_ID_PC, IF_ID_inst, IF_ID_Enable} !== {32'h4, 32'h1004, 1'b1}) begin
      n_fail++; $display("FAIL fetch_i4: got %h/%h/%b want 4/1004/1", IF_ID_PC, IF_ID_inst, IF_ID_Enable);
    end
    n_tests++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h8}) begin
      n_fail++; $display("FAIL fetch_req8: got %b/%h want 1/8", imem_req, imem_addr);
    end
  endtask

  task automatic test_stall_skid();
    stall = 1'b1;
    tick();  // 0x8 accepted
    tick();  // 0x8 response goes to skid
    n_tests++;
    if ({IF_ID_PC, IF_ID_inst, IF_ID_Enable} !== {32'h4, 32'h1004, 1'b1}) begin
      n_fail++; $display("FAIL stall_hold: got %h/%h/%b want 4/1004/1", IF_ID_PC, IF_ID_inst, IF_ID_Enable);
    end
    n_tests++;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_noreq: got %b want 0", imem_req); end
    tick();
    n_tests++;
    if (dbg_state !== HOLD) begin n_fail++; $display("FAIL stall_hold_state: got %0d want HOLD", dbg_state); end
    n_tests++;
    if ({imem_req, IF_ID_PC, IF_ID_Enable} !== {1'b0, 32'h4, 1'b1}) begin
      n_fail++; $display("FAIL stall_hold2: got req=%b pc=%h en=%b want 0/4/1", imem_req, IF_ID_PC, IF_ID_Enable);
    end
    stall = 1'b0;
    tick();
    n_tests++;
    if ({IF_ID_PC, IF_ID_inst, IF_ID_Enable} !== {32'h8, 32'h1008, 1'b1}) begin
      n_fail++; $display("FAIL skid_out: got %h/%h/%b want 8/1008/1", IF_ID_PC, IF_ID_inst, IF_ID_Enable);
    end
    n_tests++;
    if ({imem_req, imem_addr} !== {1'b1, 32'hC}) begin
      n_fail++; $display("FAIL skid_reqC: got %b/%h want 1/c", imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_wait();
    tick(); tick();
    n_tests++;
    if ({IF_ID_PC, IF_ID_Enable} !== {32'hC, 1'b1}) begin
      n_fail++; $display("FAIL rw_iC: got %h/%b want c/1", IF_ID_PC, IF_ID_Enable);
    end
    tick();  // 0x10 accepted; hold its response back
    mem_mute = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    n_tests++;
    if ({imem_req, IF_ID_Enable, dbg_state} !== {1'b0, 1'b0, WAIT}) begin
      n_fail++; $display("FAIL rw_wait: got req=%b en=%b st=%0d want 0/0/WAIT", imem_req, IF_ID_Enable, dbg_state);
    end
    redirect_valid = 1'b0; mem_mute = 1'b0;
    tick();  // stale 0x10 response arrives
    n_tests++;
    if ({IF_ID_PC, IF_ID_inst, IF_ID_Enable} !== {32'h0, 32'h0, 1'b0}) begin
      n_fail++; $display("FAIL rw_drop: got %h/%h/%b want 0/0/0", IF_ID_PC, IF_ID_inst, IF_ID_Enable);
    end
    n_tests++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h40}) begin
      n_fail++; $display("FAIL rw_req40: got %b/%h want 1/40", imem_req, imem_addr);
    end
    tick(); tick();
    n_tests++;
    if ({IF_ID_PC, IF_ID_inst, IF_ID_Enable} !== {32'h40, 32'h1040, 1'b1}) begin
      n_fail++; $display("FAIL rw_i40: got %h/%h/%b want 40/1040/1", IF_ID_PC, IF_ID_inst, IF_ID_Enable);
    end
`ifdef IF_ID_PERF_EN
    n_tests++;
    if ({perf_fetch_cnt, perf_drop_cnt} !== {32'd5, 32'd1}) begin
      n_fail++; $display("FAIL rw_perf: got %0d/%0d want 5/1", perf_fetch_cnt, perf_drop_cnt);
    end
`endif
  endtask

  task automatic test_redirect_stall_skid();
    stall = 1'b1;
    tick(); tick();  // 0x44 parked in skid
    n_tests++;
    if ({dbg_state, IF_ID_PC} !== {HOLD, 32'h40}) begin
      n_fail++; $display("FAIL rs_full: got st=%0d pc=%h want HOLD/40", dbg_state, IF_ID_PC);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    tick();
    n_tests++;
    if ({IF_ID_PC, IF_ID_inst, IF_ID_Enable} !== {32'h0, 32'h0, 1'b0}) begin
      n_fail++; $display("FAIL rs_bubble: got %h/%h/%b want 0/0/0", IF_ID_PC, IF_ID_inst, IF_ID_Enable);
    end
    n_tests++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h80}) begin
      n_fail++; $display("FAIL rs_req80: got %b/%h want 1/80", imem_req, imem_addr);
    end
    redirect_valid = 1'b0; stall = 1'b0;
    tick();
    n_tests++;
    if (IF_ID_Enable !== 1'b0) begin n_fail++; $display("FAIL rs_noskid: got en=%b pc=%h want 0", IF_ID_Enable, IF_ID_PC); end
    tick();
    n_tests++;
    if ({IF_ID_PC, IF_ID_inst, IF_ID_Enable} !== {32'h80, 32'h1080, 1'b1}) begin
      n_fail++; $display("FAIL rs_i80: got %h/%h/%b want 80/1080/1", IF_ID_PC, IF_ID_inst, IF_ID_Enable);
    end
  endtask

  task automatic test_redirect_req();
    imem_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h43;
    tick();
    n_tests++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h40}) begin
      n_fail++; $display("FAIL align_40: got %b/%h want 1/40", imem_req, imem_addr);
    end
    imem_ready = 1'b1; redirect_pc = 32'h100;
    tick();  // 0x40 accepted together with the redirect
    n_tests++;
    if ({imem_req, dbg_state} !== {1'b0, WAIT}) begin
      n_fail++; $display("FAIL rq_wait: got req=%b st=%0d want 0/WAIT", imem_req, dbg_state);
    end
    redirect_valid = 1'b0;
    tick();
    n_tests++;
    if ({IF_ID_Enable, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h100}) begin
      n_fail++; $display("FAIL rq_req100: got en=%b req=%b addr=%h want 0/1/100", IF_ID_Enable, imem_req, imem_addr);
    end
    tick(); tick();
    n_tests++;
    if ({IF_ID_PC, IF_ID_inst, IF_ID_Enable} !== {32'h100, 32'h1100, 1'b1}) begin
      n_fail++; $display("FAIL rq_i100: got %h/%h/%b want 100/1100/1", IF_ID_PC, IF_ID_inst, IF_ID_Enable);
    end
`ifdef IF_ID_PERF_EN
    n_tests++;
    if ({perf_fetch_cnt, perf_drop_cnt} !== {32'd7, 32'd3}) begin
      n_fail++; $display("FAIL rq_perf: got %0d/%0d want 7/3", perf_fetch_cnt, perf_drop_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid();
    tick();  // 0x104 accepted, now WAIT
    mem_mute = 1'b1; rst = 1'b1;
    tick();
    n_tests++;
    if ({IF_ID_PC, IF_ID_inst, IF_ID_Enable, imem_req} !== {32'h0, 32'h0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL rm_zero: got %h/%h/%b req=%b want all 0", IF_ID_PC, IF_ID_inst, IF_ID_Enable, imem_req);
    end
    rst = 1'b0; mem_mute = 1'b0;
    tick();  // late rvalid while IDLE
    n_tests++;
    if ({IF_ID_Enable, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h0}) begin
      n_fail++; $display("FAIL rm_ignore: got en=%b req=%b addr=%h want 0/1/0", IF_ID_Enable, imem_req, imem_addr);
    end
`ifdef IF_ID_PERF_EN
    n_tests++;
    if ({perf_fetch_cnt, perf_drop_cnt} !== 64'h0) begin
      n_fail++; $display("FAIL rm_perf: got %0d/%0d want 0/0", perf_fetch_cnt, perf_drop_cnt);
    end
`endif
    tick(); tick();
    n_tests++;
    if ({IF_ID_PC, IF_ID_inst, IF_ID_Enable} !== {32'h0, 32'h1000, 1'b1}) begin
      n_fail++; $display("FAIL rm_i0: got %h/%h/%b want 0/1000/1", IF_ID_PC, IF_ID_inst, IF_ID_Enable);
    end
  endtask

  task automatic test_wrap();
    imem_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect_valid = 1'b0; imem_ready = 1'b1;
    n_tests++;
    if (imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_req: got %h want fffffffc", imem_addr); end
    tick(); tick();
    n_tests++;
    if ({IF_ID_PC, IF_ID_Enable} !== {32'hFFFF_FFFC, 1'b1}) begin
      n_fail++; $display("FAIL wrap_inst: got %h/%b want fffffffc/1", IF_ID_PC, IF_ID_Enable);
    end
    n_tests++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      n_fail++; $display("FAIL wrap_pc: got %b/%h want 1/0", imem_req, imem_addr);
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  // Test sequence and final report
  initial begin
    test_reset();
    test_fetch();
    test_stall_skid();
    test_redirect_wait();
    test_redirect_stall_skid();
    test_redirect_req();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
